// File: rtl/icache_assoc.sv
// ---------------------------------------------------------------------------
// icache_assoc : set-associative instruction cache between ifetcher and mctrl
//
// Lookup is combinational on ifetch_pc. A miss fills the whole line, one
// 32-bit word per mctrl transaction, starting at the line base address. The
// word arriving from mctrl is forwarded to the ifetcher when its address
// equals ifetch_pc. flush invalidates every line and aborts a running fill.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable, rdy=0 freezes all state
//   flush           invalidate all lines, abort fill
//   ifetch_pc       fetch pc (word aligned)
//   ifetch_dout     instruction to ifetcher
//   ifetch_enable   ifetch_dout valid for ifetch_pc this cycle
//   mem_aout        word address to mctrl
//   mem_enable      request word at mem_aout
//   mem_valid       mctrl returns word for mem_aout
//   mem_din         word from mctrl
//   hit_cnt/miss_cnt  performance counters, only with ICACHE_PERF_EN defined
//
// Optional feature macro: ICACHE_PERF_EN
// ---------------------------------------------------------------------------
module icache_assoc #(
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [31:0] ifetch_pc,
  output logic [31:0] ifetch_dout,
  output logic        ifetch_enable,
  output logic [31:0] mem_aout,
  output logic        mem_enable,
  input  logic        mem_valid,
  input  logic [31:0] mem_din
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OB  = $clog2(LINE_WORDS);
  localparam int IB  = $clog2(SETS);
  localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CB  = (OB > 0) ? OB : 1;
  localparam int TLO = 2 + OB + IB;
  localparam int TB  = ADDR_BITS - TLO;

  localparam logic [31:0]   LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [31:0]   OFF_MASK  = 32'(LINE_WORDS - 1);
  localparam logic [31:0]   IDX_MASK  = 32'(SETS - 1);
  localparam logic [CB-1:0] CNT_LAST  = CB'(LINE_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // storage
  logic [WAYS-1:0] valid_q [SETS];
  logic [TB-1:0]   tag_q   [SETS][WAYS];
  logic [31:0]     data_q  [SETS][WAYS][LINE_WORDS];
  logic [WB-1:0]   rr_q    [SETS];

  // fill engine
  state_e        state_q;
  logic          mem_enable_q;
  logic [31:0]   mem_aout_q;
  logic [31:0]   fill_base_q;
  logic [IB-1:0] fill_idx_q;
  logic [TB-1:0] fill_tag_q;
  logic [WB-1:0] victim_q;
  logic [CB-1:0] cnt_q;

  // lookup decode
  logic [31:0]     off_full_s;
  logic [31:0]     idx_full_s;
  logic [31:0]     tag_full_s;
  logic [CB-1:0]   off_s;
  logic [IB-1:0]   idx_s;
  logic [TB-1:0]   tag_s;
  logic [WAYS-1:0] way_match_s;
  logic            hit_s;
  logic [WB-1:0]   hit_way_s;
  logic [WB-1:0]   victim_s;
  logic            fwd_s;
  logic            start_fill_s;
  logic [CB-1:0]   cnt_nx_s;

  assign off_full_s = (ifetch_pc >> 2) & OFF_MASK;
  assign idx_full_s = (ifetch_pc >> (2 + OB)) & IDX_MASK;
  assign tag_full_s = ifetch_pc >> TLO;
  assign off_s      = off_full_s[CB-1:0];
  assign idx_s      = idx_full_s[IB-1:0];
  assign tag_s      = tag_full_s[TB-1:0];
  assign cnt_nx_s   = cnt_q + CB'(1);

  // tag compare, hit way select and victim choice for the indexed set
  always_comb begin
    way_match_s = '0;
    hit_way_s   = '0;
    victim_s    = rr_q[idx_s];
    for (int w = 0; w < WAYS; w++) begin
      way_match_s[w] = valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s);
      hit_way_s      = way_match_s[w] ? WB'(w) : hit_way_s;
    end
    // scan downward so the lowest invalid way wins over the round-robin pointer
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim_s = valid_q[idx_s][w] ? victim_s : WB'(w);
    end
    hit_s = |way_match_s;
  end

  // forwarding of the word currently being returned by mctrl
  assign fwd_s = (state_q == FILL) && mem_valid && (mem_aout_q == ifetch_pc);

  assign ifetch_enable = hit_s | fwd_s;
  assign ifetch_dout   = hit_s ? data_q[idx_s][hit_way_s][off_s] : mem_din;
  assign mem_aout      = mem_aout_q;
  assign mem_enable    = mem_enable_q;

  assign start_fill_s = rdy && !flush && (state_q == IDLE) && !hit_s;

  // fill FSM, valid/tag arrays and replacement pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_aout_q   <= 32'h0000_0000;
      fill_base_q  <= 32'h0000_0000;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        // any partial line is dropped; its victim way was already invalidated
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
        end
        mem_enable_q <= 1'b0;
        state_q      <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (!hit_s) begin
              // victim goes invalid now so its old contents never hit while being overwritten
              valid_q[idx_s][victim_s] <= 1'b0;
              fill_base_q  <= ifetch_pc & ~LINE_MASK;
              mem_aout_q   <= ifetch_pc & ~LINE_MASK;
              fill_idx_q   <= idx_s;
              fill_tag_q   <= tag_s;
              victim_q     <= victim_s;
              cnt_q        <= '0;
              mem_enable_q <= 1'b1;
              state_q      <= FILL;
            end else begin
              state_q <= IDLE;
            end
          end
          FILL: begin
            if (mem_valid) begin
              if (cnt_q == CNT_LAST) begin
                valid_q[fill_idx_q][victim_q] <= 1'b1;
                tag_q[fill_idx_q][victim_q]   <= fill_tag_q;
                rr_q[fill_idx_q] <= (WAYS == 1) ? '0 : rr_q[fill_idx_q] + WB'(1);
                mem_enable_q <= 1'b0;
                state_q      <= IDLE;
              end else begin
                // offset bits only: the address never carries out of the line
                cnt_q      <= cnt_nx_s;
                mem_aout_q <= fill_base_q | (32'(cnt_nx_s) << 2);
              end
            end else begin
              state_q <= FILL;
            end
          end
          default: begin
            mem_enable_q <= 1'b0;
            state_q      <= IDLE;
          end
        endcase
      end
    end
  end

  // line data write; a word arriving together with flush is discarded
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && (state_q == FILL) && mem_valid) begin
      data_q[fill_idx_q][victim_q][cnt_q] <= mem_din;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] last_pc_q;

  // hit counts only new pcs; misses count fill starts; flush leaves counters alone
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
      last_pc_q  <= 32'h0000_0000;
    end else if (rdy) begin
      last_pc_q <= ifetch_pc;
      if (hit_s && (ifetch_pc != last_pc_q)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start_fill_s) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_s;
  assign unused_s = start_fill_s;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
module tb_icache_assoc;

  localparam int SETS = 64;
  localparam int WAYS = 2;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, mem_valid;
  logic [31:0] ifetch_pc, mem_din;
  logic [31:0] ifetch_dout, mem_aout;
  logic        ifetch_enable, mem_enable;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_assoc dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ifetch_pc(ifetch_pc), .ifetch_dout(ifetch_dout), .ifetch_enable(ifetch_enable),
    .mem_aout(mem_aout), .mem_enable(mem_enable),
    .mem_valid(mem_valid), .mem_din(mem_din)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // reference model: lines identified by (set, tag); data is a pure function of address
  bit          mv  [SETS][WAYS];
  int          mtg [SETS][WAYS];
  int          mrr [SETS];
  bit          mfill;
  int          mset, mway, mcnt, mtag;
  logic [31:0] mbase, maout;
  logic        men;
  logic [31:0] mhits, mmiss, mlast;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 4) % SETS);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc % 32'h0004_0000) / (16 * SETS));
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    for (int w = 0; w < WAYS; w++)
      if (mv[set_of(pc)][w] && mtg[set_of(pc)][w] == tag_of(pc)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    bit h;
    bit e;
    h = mhit(ifetch_pc);
    e = h || (mfill && mem_valid && maout == ifetch_pc);
    chk("ifetch_enable", {31'b0, ifetch_enable}, {31'b0, e});
    if (e) chk("ifetch_dout", ifetch_dout, h ? memfn(ifetch_pc) : mem_din);
    chk("mem_enable", {31'b0, mem_enable}, {31'b0, men});
    if (men) chk("mem_aout", mem_aout, maout);
`ifdef ICACHE_PERF_EN
    chk("hit_cnt", hit_cnt, mhits);
    chk("miss_cnt", miss_cnt, mmiss);
`endif
  endtask

  task automatic clear_valid();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
  endtask

  task automatic model_update();
    bit h;
    int s, v;
    h = mhit(ifetch_pc);
    s = set_of(ifetch_pc);
    if (rst) begin
      clear_valid();
      for (int i = 0; i < SETS; i++) mrr[i] = 0;
      mfill = 1'b0; men = 1'b0; maout = 32'h0;
      mhits = 32'h0; mmiss = 32'h0; mlast = 32'h0;
    end else if (rdy) begin
      if (h && ifetch_pc != mlast) mhits = mhits + 32'd1;
      mlast = ifetch_pc;
      if (flush) begin
        clear_valid();
        mfill = 1'b0; men = 1'b0;
      end else if (!mfill) begin
        if (!h) begin
          v = mrr[s];
          for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
          mv[s][v] = 1'b0;
          mfill = 1'b1; mset = s; mway = v; mtag = tag_of(ifetch_pc);
          mbase = ifetch_pc & ~32'hF; mcnt = 0; men = 1'b1; maout = mbase;
          mmiss = mmiss + 32'd1;
        end
      end else if (mem_valid) begin
        if (mcnt == LW - 1) begin
          mv[mset][mway] = 1'b1; mtg[mset][mway] = mtag;
          mrr[mset] = (mrr[mset] + 1) % WAYS;
          mfill = 1'b0; men = 1'b0;
        end else begin
          mcnt++;
          maout = mbase + 32'(4 * mcnt);
        end
      end
    end
  endtask

  // inputs change at posedge+1, outputs are checked at posedge+5
  task automatic tick();
    #4;
    check_outs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_mem(input int pct);
    mem_valid = men && ($urandom_range(99) < pct);
    mem_din   = mem_valid ? memfn(maout) : $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; mem_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_line(input logic [31:0] pc);
    ifetch_pc = pc; rdy = 1'b1; flush = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (!mfill && mhit(pc)) break;
      drive_mem(70);
      tick();
    end
    mem_valid = 1'b0;
    #2;
    chk("fill_hit", {31'b0, ifetch_enable}, 32'd1);
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic exp_en);
    ifetch_pc = pc; mem_valid = 1'b0;
    #2;
    chk(tag, {31'b0, ifetch_enable}, {31'b0, exp_en});
    if (exp_en) chk({tag, "_data"}, ifetch_dout, memfn(pc));
  endtask

  logic [31:0] a;
  logic [31:0] held;

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; mem_valid = 1'b0;
    mem_din = 32'h0; ifetch_pc = 32'h100;
    @(posedge clk);
    model_update();
    #1;
    rst = 1'b0;
    #2;
    chk("rst_mem_enable", {31'b0, mem_enable}, 32'd0);
    chk("rst_mem_aout", mem_aout, 32'd0);
    chk("rst_miss", {31'b0, ifetch_enable}, 32'd0);

    // 1: cold miss at 0x100, words in order, forwarding of the first word
    tick();
    for (int k = 0; k < LW; k++) begin
      drive_mem(100);
      a = 32'h100 + 32'(4 * k);
      #2;
      chk("t1_aout", mem_aout, a);
      if (k == 0) begin
        chk("t1_fwd_en", {31'b0, ifetch_enable}, 32'd1);
        chk("t1_fwd_data", ifetch_dout, memfn(32'h100));
      end
      tick();
    end
    probe("t1_hit108", 32'h108, 1'b1);
    tick();

    // 2: three conflicting lines in set 0
    do_reset();
    fill_line(32'h0000);
    fill_line(32'h0400);
    fill_line(32'h0800);
    probe("t2_hit400", 32'h0400, 1'b1);
    tick();
    probe("t2_miss000", 32'h0000, 1'b0);
    tick();
    fill_line(32'h0000);

    // 3: flush during the second word of a fill
    do_reset();
    fill_line(32'h100);
    ifetch_pc = 32'h200; drive_mem(0); tick();
    drive_mem(100); tick();
    drive_mem(100); flush = 1'b1; tick();
    flush = 1'b0; drive_mem(0);
    #2;
    chk("t3_cancel", {31'b0, mem_enable}, 32'd0);
    tick();
    drive_mem(0);
    #2;
    chk("t3_restart_en", {31'b0, mem_enable}, 32'd1);
    chk("t3_restart_aout", mem_aout, 32'h200);
    fill_line(32'h200);
    probe("t3_miss100", 32'h100, 1'b0);
    tick();

    // 4: rdy low mid-fill with mem_valid high
    do_reset();
    ifetch_pc = 32'h300; drive_mem(0); tick();
    drive_mem(100); tick();
    held = mem_aout;
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mem_valid = 1'b1; mem_din = memfn(maout);
      #2;
      chk("t4_aout_frozen", mem_aout, held);
      tick();
    end
    rdy = 1'b1;
    fill_line(32'h300);

    // 5: reset in the middle of a fill
    do_reset();
    fill_line(32'h100);
    ifetch_pc = 32'h500; drive_mem(0); tick();
    drive_mem(100); tick();
    rst = 1'b1; mem_valid = 1'b0; tick();
    rst = 1'b0;
    #2;
    chk("t5_mem_enable", {31'b0, mem_enable}, 32'd0);
    chk("t5_miss500", {31'b0, ifetch_enable}, 32'd0);
    probe("t5_miss100", 32'h100, 1'b0);
    tick();

`ifdef ICACHE_PERF_EN
    // 6: performance counters
    do_reset();
    fill_line(32'h0);
    chk("t6_miss_cnt", miss_cnt, 32'd1);
    ifetch_pc = 32'h0; tick();
    ifetch_pc = 32'h4; tick();
    ifetch_pc = 32'h0; tick();
    #2;
    chk("t6_hit_cnt", hit_cnt, mhits);
`endif

    // random traffic over a few conflicting sets
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(9) < 3)
        ifetch_pc = 32'($urandom_range(3)) * 32'h400 + 32'($urandom_range(3)) * 32'h10
                  + 32'($urandom_range(3)) * 32'h4;
      rdy   = ($urandom_range(9) != 0);
      flush = ($urandom_range(99) < 2);
      rst   = ($urandom_range(299) == 0);
      drive_mem(60);
      tick();
    end
    rst = 1'b0; flush = 1'b0; rdy = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
